// File: rtl/clock_pkg.sv
// Shared encodings, field widths and field limits for the digital clock.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_SET   = 2'd3
  } state_t;

  localparam int unsigned TENTHS_W = 4;
  localparam int unsigned SEC_W    = 6;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HR_W     = 5;

  localparam logic [TENTHS_W-1:0] TENTHS_MAX = 4'd9;
  localparam logic [SEC_W-1:0]    SEC_MAX    = 6'd59;
  localparam logic [MIN_W-1:0]    MIN_MAX    = 6'd59;
  localparam logic [HR_W-1:0]     HR_MAX     = 5'd23;

endpackage

// File: rtl/tick_prescaler.sv
// 100 ms timebase: counts while running, holds while paused, clears on request.
// o_wrap_c flags the wrapping edge so the time fields update together with o_tick.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_tick,
  output logic o_wrap_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Clear has priority, so a clear on the last count drops the tick.
  assign o_wrap_c = i_run && !i_clr && (cnt == CNT_LAST);

  // Prescaler count and registered tick strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else begin
      o_tick <= o_wrap_c;
      if (i_clr) begin
        cnt <= '0;
      end else if (i_run) begin
        cnt <= o_wrap_c ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_mode_controller.sv
// Run/pause/set mode FSM plus the tenths/seconds/minutes/hours carry chain.
module clock_mode_controller
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_set,
  input  logic                i_inc_min,
  input  logic                i_inc_hr,
  output logic [TENTHS_W-1:0] o_tenths,
  output logic [SEC_W-1:0]    o_sec,
  output logic [MIN_W-1:0]    o_min,
  output logic [HR_W-1:0]     o_hr,
  output logic [1:0]          o_state,
  output logic                o_tick
);

  state_t state;
  logic   run_c;
  logic   clr_c;
  logic   wrap_c;
  logic   enter_set_c;

  assign run_c       = (state == ST_RUN);
  assign enter_set_c = i_set && (state != ST_SET);
  // Leaving RUN for SET clears now so a coincident wrap is dropped.
  assign clr_c       = (state == ST_IDLE) || (state == ST_SET) || (run_c && i_set);
  assign o_state     = state;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (run_c),
    .i_clr    (clr_c),
    .o_tick   (o_tick),
    .o_wrap_c (wrap_c)
  );

  // Mode FSM; set beats stop beats start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_set)        state <= ST_SET;
          else if (i_start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (i_set)       state <= ST_SET;
          else if (i_stop) state <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (i_set)        state <= ST_SET;
          else if (i_start) state <= ST_RUN;
        end
        ST_SET: begin
          if (i_set) state <= ST_PAUSE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Time fields: SET entry clears sub-minute fields, ticks ripple, SET increments.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tenths <= '0;
      o_sec    <= '0;
      o_min    <= '0;
      o_hr     <= '0;
    end else if (enter_set_c) begin
      o_tenths <= '0;
      o_sec    <= '0;
    end else if (wrap_c) begin
      if (o_tenths != TENTHS_MAX) begin
        o_tenths <= o_tenths + TENTHS_W'(1);
      end else begin
        o_tenths <= '0;
        if (o_sec != SEC_MAX) begin
          o_sec <= o_sec + SEC_W'(1);
        end else begin
          o_sec <= '0;
          if (o_min != MIN_MAX) begin
            o_min <= o_min + MIN_W'(1);
          end else begin
            o_min <= '0;
            o_hr  <= (o_hr == HR_MAX) ? '0 : o_hr + HR_W'(1);
          end
        end
      end
    end else if (state == ST_SET) begin
      if (i_inc_min) o_min <= (o_min == MIN_MAX) ? '0 : o_min + MIN_W'(1);
      if (i_inc_hr)  o_hr  <= (o_hr == HR_MAX) ? '0 : o_hr + HR_W'(1);
    end
  end

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed bench for clock_mode_controller with a 4-cycle timebase.
module tb_clock_mode_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, set = 1'b0, inc_min = 1'b0, inc_hr = 1'b0;
  logic [3:0] tenths;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic [1:0] state;
  logic       tick;

  int n_vec = 0;
  int n_err = 0;

  clock_mode_controller #(.TICK_DIV(4), .CNT_W(3)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_stop    (stop),
    .i_set     (set),
    .i_inc_min (inc_min),
    .i_inc_hr  (inc_hr),
    .o_tenths  (tenths),
    .o_sec     (sec),
    .o_min     (min),
    .o_hr      (hr),
    .o_state   (state),
    .o_tick    (tick)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] tm(input int h, input int m, input int s, input int t);
    return {5'(h), 6'(m), 6'(s), 4'(t)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    n_vec++;
    if ({hr, min, sec, tenths} !== tm(0, 0, 0, 0) || state !== 2'd0 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset: time %0d:%0d:%0d.%0d state %0d tick %0b, want 0:0:0.0 state 0 tick 0",
               hr, min, sec, tenths, state, tick);
    end
  endtask

  task automatic test_run_ticks();
    int early = 0;
    int ticks = 0;
    start = 1'b1; cyc(); start = 1'b0;
    n_vec++;
    if (state !== 2'd1) begin n_err++; $display("FAIL start_state: got %0d want 1", state); end
    for (int i = 0; i < 3; i++) begin cyc(); if (tick) early++; end
    n_vec++;
    if (early !== 0) begin n_err++; $display("FAIL first_tick_early: %0d ticks before cycle 4", early); end
    cyc();
    n_vec++;
    if (tick !== 1'b1 || tenths !== 4'd1) begin
      n_err++; $display("FAIL first_tick: tick %0b tenths %0d want 1 and 1", tick, tenths);
    end
    for (int i = 0; i < 36; i++) begin cyc(); if (tick) ticks++; end
    n_vec++;
    if (ticks !== 9 || {hr, min, sec, tenths} !== tm(0, 0, 1, 0)) begin
      n_err++;
      $display("FAIL ten_ticks: ticks %0d time %0d:%0d:%0d.%0d want 9 and 0:0:1.0", ticks, hr, min, sec, tenths);
    end
  endtask

  task automatic test_pause_resume();
    int seen = 0;
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    for (int i = 0; i < 20; i++) begin cyc(); if (tick) seen++; end
    n_vec++;
    if (seen !== 0 || state !== 2'd2 || {hr, min, sec, tenths} !== tm(0, 0, 1, 0)) begin
      n_err++;
      $display("FAIL pause_hold: ticks %0d state %0d time %0d:%0d:%0d.%0d want 0 2 0:0:1.0",
               seen, state, hr, min, sec, tenths);
    end
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    n_vec++;
    if (tick !== 1'b0) begin n_err++; $display("FAIL resume_early: tick %0b want 0", tick); end
    cyc();
    n_vec++;
    if (tick !== 1'b1 || {hr, min, sec, tenths} !== tm(0, 0, 1, 1)) begin
      n_err++;
      $display("FAIL resume_tick: tick %0b time %0d:%0d:%0d.%0d want 1 0:0:1.1", tick, hr, min, sec, tenths);
    end
  endtask

  task automatic test_stop_on_wrap();
    cyc(); cyc(); cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    n_vec++;
    if (tick !== 1'b1 || state !== 2'd2 || tenths !== 4'd2) begin
      n_err++;
      $display("FAIL stop_on_wrap: tick %0b state %0d tenths %0d want 1 2 2", tick, state, tenths);
    end
  endtask

  task automatic test_set_priority();
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    set = 1'b1; cyc(); set = 1'b0;
    n_vec++;
    if (tick !== 1'b0 || state !== 2'd3 || {hr, min, sec, tenths} !== tm(0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL set_on_wrap: tick %0b state %0d time %0d:%0d:%0d.%0d want 0 3 0:0:0.0",
               tick, state, hr, min, sec, tenths);
    end
    set = 1'b1; cyc(); set = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    set = 1'b1; stop = 1'b1; cyc(); set = 1'b0; stop = 1'b0;
    n_vec++;
    if (state !== 2'd3) begin n_err++; $display("FAIL set_beats_stop: state %0d want 3", state); end
    inc_min = 1'b1; inc_hr = 1'b1; cyc(); inc_min = 1'b0; inc_hr = 1'b0;
    n_vec++;
    if ({hr, min} !== {5'd1, 6'd1}) begin
      n_err++; $display("FAIL dual_inc: hr %0d min %0d want 1 1", hr, min);
    end
  endtask

  task automatic test_set_mode();
    rst = 1'b1; cyc(); rst = 1'b0;
    set = 1'b1; inc_hr = 1'b1; cyc(); set = 1'b0;
    n_vec++;
    if (state !== 2'd3 || hr !== 5'd0) begin
      n_err++; $display("FAIL set_entry_inc: state %0d hr %0d want 3 0", state, hr);
    end
    for (int i = 0; i < 5; i++) cyc();
    inc_hr = 1'b0;
    inc_min = 1'b1;
    for (int i = 0; i < 61; i++) cyc();
    inc_min = 1'b0;
    set = 1'b1; cyc(); set = 1'b0;
    n_vec++;
    if (state !== 2'd2 || {hr, min, sec, tenths} !== tm(5, 1, 0, 0)) begin
      n_err++;
      $display("FAIL set_result: state %0d time %0d:%0d:%0d.%0d want 2 5:1:0.0", state, hr, min, sec, tenths);
    end
    inc_min = 1'b1; inc_hr = 1'b1; cyc(); inc_min = 1'b0; inc_hr = 1'b0;
    n_vec++;
    if ({hr, min} !== {5'd5, 6'd1}) begin
      n_err++; $display("FAIL inc_outside_set: hr %0d min %0d want 5 1", hr, min);
    end
  endtask

  task automatic test_rollover();
    rst = 1'b1; cyc(); rst = 1'b0;
    set = 1'b1; cyc(); set = 1'b0;
    inc_hr = 1'b1; for (int i = 0; i < 23; i++) cyc(); inc_hr = 1'b0;
    inc_min = 1'b1; for (int i = 0; i < 59; i++) cyc(); inc_min = 1'b0;
    set = 1'b1; cyc(); set = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 599 * 4; i++) cyc();
    n_vec++;
    if ({hr, min, sec, tenths} !== tm(23, 59, 59, 9)) begin
      n_err++; $display("FAIL preload: time %0d:%0d:%0d.%0d want 23:59:59.9", hr, min, sec, tenths);
    end
    for (int i = 0; i < 4; i++) cyc();
    n_vec++;
    if (tick !== 1'b1 || {hr, min, sec, tenths} !== tm(0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL rollover: tick %0b time %0d:%0d:%0d.%0d want 1 0:0:0.0", tick, hr, min, sec, tenths);
    end
  endtask

  task automatic test_reset_mid_run();
    int early = 0;
    rst = 1'b1; cyc(); rst = 1'b0;
    set = 1'b1; cyc(); set = 1'b0;
    inc_min = 1'b1; for (int i = 0; i < 12; i++) cyc(); inc_min = 1'b0;
    set = 1'b1; cyc(); set = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 345 * 4; i++) cyc();
    n_vec++;
    if (state !== 2'd1 || {hr, min, sec, tenths} !== tm(0, 12, 34, 5)) begin
      n_err++;
      $display("FAIL mid_run: state %0d time %0d:%0d:%0d.%0d want 1 0:12:34.5", state, hr, min, sec, tenths);
    end
    cyc(); cyc(); cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    n_vec++;
    if (state !== 2'd0 || tick !== 1'b0 || {hr, min, sec, tenths} !== tm(0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL reset_mid_run: state %0d tick %0b time %0d:%0d:%0d.%0d want 0 0 0:0:0.0",
               state, tick, hr, min, sec, tenths);
    end
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc(); if (tick) early++; end
    cyc();
    n_vec++;
    if (early !== 0 || tick !== 1'b1) begin
      n_err++; $display("FAIL post_reset_tick: early %0d tick %0b want 0 1", early, tick);
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_run_ticks();
    test_pause_resume();
    test_stop_on_wrap();
    test_set_priority();
    test_set_mode();
    test_rollover();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
